// File: rtl/fp_multiplier_if.sv
// rtl/fp_multiplier_if.sv - operand/result bundle for the sequential FP multiplier
interface fp_multiplier_if;
  logic        start;
  logic [31:0] FP1;
  logic [31:0] FP2;
  logic [31:0] result;
  logic        ovf;

  modport master (output start, FP1, FP2, input result, ovf);
  modport slave  (input start, FP1, FP2, output result, ovf);
endinterface

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - sequential IEEE-754 single multiplier, 24-step shift-add, RNE rounding
module fp_multiplier (
  input logic            clk,
  input logic            reset,
  fp_multiplier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MULT, NORM, PACK, DONE} state_t;
  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

  state_t             state, state_next;
  kind_t              kind, kind_in;
  logic               sign;
  logic signed [9:0]  exp_acc;
  logic [47:0]        mcand, acc;
  logic [23:0]        mplier;
  logic [4:0]         cnt;
  logic [22:0]        frac;
  logic               guard, sticky;
  logic [31:0]        result_q;
  logic               ovf_q;

  logic [7:0]         e1, e2;
  logic               z1, z2, inf1, inf2, nan1, nan2;
  logic               round_up;
  logic [23:0]        rounded;
  logic signed [9:0]  exp_fin;
  logic [31:0]        packed_res;
  logic               packed_ovf;

  assign e1   = bus.FP1[30:23];
  assign e2   = bus.FP2[30:23];
  assign z1   = (e1 == 8'h00);
  assign z2   = (e2 == 8'h00);
  assign inf1 = (e1 == 8'hFF) && (bus.FP1[22:0] == 23'd0);
  assign inf2 = (e2 == 8'hFF) && (bus.FP2[22:0] == 23'd0);
  assign nan1 = (e1 == 8'hFF) && (bus.FP1[22:0] != 23'd0);
  assign nan2 = (e2 == 8'hFF) && (bus.FP2[22:0] != 23'd0);

  // Denormals count as zero, so Inf x denormal is also NaN
  always_comb begin
    kind_in = K_NUM;
    if (nan1 || nan2 || (inf1 && z2) || (inf2 && z1))
      kind_in = K_NAN;
    else if (inf1 || inf2)
      kind_in = K_INF;
    else if (z1 || z2)
      kind_in = K_ZERO;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = MULT;
      MULT:    if (cnt == 5'd23) state_next = NORM;
      NORM:    state_next = PACK;
      PACK:    state_next = DONE;
      DONE:    if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    round_up   = guard & (sticky | frac[0]);
    rounded    = {1'b0, frac} + {23'd0, round_up};
    exp_fin    = exp_acc + (rounded[23] ? 10'sd1 : 10'sd0);
    packed_ovf = 1'b0;
    packed_res = {sign, exp_fin[7:0], rounded[22:0]};
    case (kind)
      K_NAN:  packed_res = 32'h7FC0_0000;
      K_INF:  packed_res = {sign, 8'hFF, 23'd0};
      K_ZERO: packed_res = {sign, 31'd0};
      default: begin
        if (exp_fin >= 10'sd255) begin
          packed_res = {sign, 8'hFF, 23'd0};
          packed_ovf = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
          packed_res = {sign, 31'd0};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind     <= K_NUM;
      sign     <= 1'b0;
      exp_acc  <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      frac     <= '0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          kind    <= kind_in;
          sign    <= bus.FP1[31] ^ bus.FP2[31];
          exp_acc <= $signed({2'b00, e1} + {2'b00, e2} - 10'd127);
          mcand   <= {24'd0, 1'b1, bus.FP1[22:0]};
          mplier  <= {1'b1, bus.FP2[22:0]};
          acc     <= '0;
          cnt     <= '0;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        // Leading one lands on bit 46 or 47; fraction is the 23 bits below it
        NORM: begin
          if (acc[47]) begin
            exp_acc <= exp_acc + 10'sd1;
            frac    <= acc[46:24];
            guard   <= acc[23];
            sticky  <= |acc[22:0];
          end else begin
            frac    <= acc[45:23];
            guard   <= acc[22];
            sticky  <= |acc[21:0];
          end
        end
        PACK: begin
          result_q <= packed_res;
          ovf_q    <= packed_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_fp_multiplier.sv
// tb/tb_fp_multiplier.sv - directed table, random vectors vs arithmetic model, reset/latency sequences
module tb_fp_multiplier;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;

  fp_multiplier_if bus ();
  fp_multiplier dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact integer product, then round-to-nearest-even on the remainder
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
    logic s;
    int ea, eb, e, sh;
    logic za, zb, ia, ib, na, nb;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = {24'd0, a[30:23]};
    eb = {24'd0, b[30:23]};
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    o  = 1'b0;
    if (na || nb || (ia && zb) || (ib && za)) r = 32'h7FC0_0000;
    else if (ia || ib) r = {s, 8'hFF, 23'd0};
    else if (za || zb) r = {s, 31'd0};
    else begin
      p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin r = {s, 8'hFF, 23'd0}; o = 1'b1; end
      else if (e <= 0) r = {s, 31'd0};
      else r = {s, e[7:0], q[22:0]};
    end
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                       input logic exp_o, input string name, input int drop_at);
    logic [31:0] prev;
    @(negedge clk);
    bus.FP1 = a;
    bus.FP2 = b;
    bus.start = 1'b1;
    prev = bus.result;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.FP1 = $urandom; bus.FP2 = $urandom; end
      if (k == drop_at) bus.start = 1'b0;
    end
    if (prev !== exp_r) chk({name, " early"}, bus.result, prev);
    @(posedge clk); #1;
    chk({name, " result"}, bus.result, exp_r);
    chk({name, " ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
    repeat (3) @(posedge clk);
    #1;
    chk({name, " hold"}, bus.result, exp_r);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, " idle hold"}, bus.result, exp_r);
    chk({name, " idle ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic        ro;
    int          ex;
    n_vec = 0;
    n_fail = 0;

    tbl[0] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0};
    tbl[1] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0};
    tbl[2] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0};
    tbl[3] = '{32'h0000_0000, 32'h4120_0000, 32'h0000_0000, 1'b0};
    tbl[4] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0};
    tbl[5] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0};
    tbl[6] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1};
    tbl[7] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0};
    tbl[8] = '{32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 1'b0};
    tbl[9] = '{32'hBF80_0000, 32'h3F7F_FFFF, 32'hBF7F_FFFF, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.FP1 = '0;
    bus.FP2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.result, 32'h0);
    chk("reset ovf", {31'd0, bus.ovf}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle result", bus.result, 32'h0);
    chk("idle ovf", {31'd0, bus.ovf}, 32'h0);

    do_op(32'hC190_0000, 32'h4118_0000, 32'hC32B_0000, 1'b0, "neg18x9p5", -1);

    for (int i = 0; i < 10; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o, $sformatf("vec%0d", i), -1);

    do_op(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 1'b0, "start drop", 5);

    // Asynchronous reset in the middle of MULT
    @(negedge clk);
    bus.FP1 = 32'h7F00_0000;
    bus.FP2 = 32'h7F00_0000;
    bus.start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async reset result", bus.result, 32'h0);
    chk("async reset ovf", {31'd0, bus.ovf}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.FP1 = 32'h4000_0000;
    bus.FP2 = 32'h4040_0000;
    repeat (26) @(posedge clk);
    #1;
    chk("post reset early", bus.result, 32'h0);
    @(posedge clk); #1;
    chk("post reset result", bus.result, 32'h40C0_0000);
    chk("post reset ovf", {31'd0, bus.ovf}, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post reset idle hold", bus.result, 32'h40C0_0000);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      ex = $urandom_range(0, 9);
      if (ex == 0) ra[30:23] = 8'h00;
      else if (ex == 1) rb[30:23] = 8'hFF;
      else if (ex == 2) begin ra[30:23] = 8'hFF; ra[22:0] = 23'd0; end
      else if (ex < 7) begin
        ra[30:23] = 8'($urandom_range(64, 190));
        rb[30:23] = 8'($urandom_range(64, 190));
      end
      ref_mul(ra, rb, rr, ro);
      do_op(ra, rb, rr, ro, $sformatf("rand%0d", i), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
